// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, ALU and result signals of the ALU issue controller
interface alu_issue_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             instr_valid;
  logic             instr_ready;
  logic [31:0]      instr;
  logic [31:0]      rs_data;
  logic [31:0]      rt_data;
  logic [31:0]      alu_a;
  logic [31:0]      alu_b;
  logic [5:0]       alu_signal;
  logic             alu_reset;
  logic [31:0]      alu_out;
  logic             res_valid;
  logic             res_ready;
  logic [31:0]      res_data;
  logic [4:0]       res_rd;
  logic             res_illegal;
  logic [CNT_W-1:0] op_count;
  modport slave (
    input  instr_valid, instr, rs_data, rt_data, alu_out, res_ready,
    output instr_ready, alu_a, alu_b, alu_signal, alu_reset,
           res_valid, res_data, res_rd, res_illegal, op_count
  );
  modport master (
    output instr_valid, instr, rs_data, rt_data, alu_out, res_ready,
    input  instr_ready, alu_a, alu_b, alu_signal, alu_reset,
           res_valid, res_data, res_rd, res_illegal, op_count
  );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues R-type ops to a combinational ALU and returns the settled result
module alu_issue_ctrl #(
  parameter int SETTLE_CYCLES = 1,
  parameter int CNT_W = 16
) (
  input logic clk,
  input logic reset,
  alu_issue_ctrl_if.slave bus
);
  localparam int SC = SETTLE_CYCLES < 1 ? 1 : SETTLE_CYCLES;
  localparam int CW = $clog2(SC + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    funct;
  logic          legal;
  logic          settled;
  logic          unused_fields;
  assign funct = bus.instr[5:0];
  assign legal = bus.instr[31:26] == 6'd0 &&
                 (funct == 6'd32 || funct == 6'd34 || funct == 6'd36 ||
                  funct == 6'd37 || funct == 6'd42);
  // illegal ops spend a single ISSUE cycle so both paths share the same minimum latency
  assign settled = bus.res_illegal || cnt == CW'(SC - 1);
  assign unused_fields = ^{bus.instr[25:16], bus.instr[10:6]};
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      cnt             <= '0;
      bus.instr_ready <= 1'b1;
      bus.alu_reset   <= 1'b1;
      bus.alu_a       <= '0;
      bus.alu_b       <= '0;
      bus.alu_signal  <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_rd      <= '0;
      bus.res_illegal <= 1'b0;
      bus.op_count    <= '0;
    end else begin
      case (state)
        IDLE: if (bus.instr_valid) begin
          bus.instr_ready <= 1'b0;
          bus.res_rd      <= bus.instr[15:11];
          bus.res_data    <= '0;
          bus.res_illegal <= ~legal;
          bus.alu_reset   <= ~legal;
          cnt             <= '0;
          state           <= ISSUE;
          if (legal) begin
            bus.alu_a      <= bus.rs_data;
            bus.alu_b      <= bus.rt_data;
            bus.alu_signal <= funct;
          end
        end
        ISSUE: begin
          cnt <= cnt + 1'b1;
          if (settled) begin
            bus.res_data  <= bus.res_illegal ? 32'd0 : bus.alu_out;
            bus.res_valid <= 1'b1;
            bus.alu_reset <= 1'b1;
            state         <= RESP;
          end
        end
        RESP: if (bus.res_ready) begin
          bus.res_valid   <= 1'b0;
          bus.instr_ready <= 1'b1;
          state           <= IDLE;
          if (!bus.res_illegal) bus.op_count <= bus.op_count + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: table-driven and directed checks of alu_issue_ctrl against a behavioural ALU
module tb_alu_issue_ctrl;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  int   exp1 = 0;
  always #5 clk = ~clk;
  alu_issue_ctrl_if #(.CNT_W(16)) b1 ();
  alu_issue_ctrl_if #(.CNT_W(16)) b4 ();
  alu_issue_ctrl_if #(.CNT_W(2))  b6 ();
  alu_issue_ctrl #(.SETTLE_CYCLES(1), .CNT_W(16)) u1 (.clk(clk), .reset(reset), .bus(b1.slave));
  alu_issue_ctrl #(.SETTLE_CYCLES(4), .CNT_W(16)) u4 (.clk(clk), .reset(reset), .bus(b4.slave));
  alu_issue_ctrl #(.SETTLE_CYCLES(3), .CNT_W(2))  u6 (.clk(clk), .reset(reset), .bus(b6.slave));
  function automatic logic [31:0] alu(input logic [31:0] a, input logic [31:0] b,
                                      input logic [5:0] s, input logic r);
    if (r) return 32'd0;
    case (s)
      6'd32:   return a + b;
      6'd34:   return a - b;
      6'd36:   return a & b;
      6'd37:   return a | b;
      6'd42:   return {31'd0, $signed(a) < $signed(b)};
      default: return 32'd0;
    endcase
  endfunction
  always_comb b1.alu_out = alu(b1.alu_a, b1.alu_b, b1.alu_signal, b1.alu_reset);
  always_comb b4.alu_out = alu(b4.alu_a, b4.alu_b, b4.alu_signal, b4.alu_reset);
  always_comb b6.alu_out = alu(b6.alu_a, b6.alu_b, b6.alu_signal, b6.alu_reset);
  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd, input logic [5:0] fn);
    return {op, 5'd1, 5'd2, rd, 5'd0, fn};
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  typedef struct {
    logic [31:0] instr;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        ill;
  } vec_t;
  task automatic run1(input vec_t v);
    int lat;
    lat = 0;
    while (!b1.instr_ready && lat < 20) begin @(posedge clk); #1; lat++; end
    b1.instr = v.instr; b1.rs_data = v.a; b1.rt_data = v.b; b1.instr_valid = 1'b1;
    @(posedge clk); #1;
    b1.instr_valid = 1'b0;
    chk("ready_low_issue", b1.instr_ready, 0);
    lat = 0;
    while (!b1.res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("latency", lat, 1);
    chk("res_data", b1.res_data, v.data);
    chk("res_rd", b1.res_rd, {27'd0, v.instr[15:11]});
    chk("res_illegal", b1.res_illegal, {31'd0, v.ill});
    chk("ready_low_resp", b1.instr_ready, 0);
    if (!v.ill) begin
      chk("alu_signal", b1.alu_signal, {26'd0, v.instr[5:0]});
      chk("alu_a", b1.alu_a, v.a);
      exp1++;
    end
    @(posedge clk); #1;
    chk("res_valid_drop", b1.res_valid, 0);
    chk("op_count", b1.op_count, exp1);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    vec_t vt[8];
    logic [1:0] seq6[5];
    int lat;
    int hits;
    vt[0] = '{mk(6'd0, 5'd3,  6'd32), 32'd5,        32'd7,      32'd12,     1'b0};
    vt[1] = '{mk(6'd0, 5'd4,  6'd34), 32'd9,        32'd4,      32'd5,      1'b0};
    vt[2] = '{mk(6'd0, 5'd5,  6'd36), 32'hF0F0,     32'h0FF0,   32'h00F0,   1'b0};
    vt[3] = '{mk(6'd0, 5'd6,  6'd7),  32'd1,        32'd2,      32'd0,      1'b1};
    vt[4] = '{mk(6'd8, 5'd7,  6'd32), 32'd1,        32'd2,      32'd0,      1'b1};
    vt[5] = '{mk(6'd0, 5'd8,  6'd42), 32'hFFFFFFFF, 32'd1,      32'd1,      1'b0};
    vt[6] = '{mk(6'd0, 5'd9,  6'd42), 32'd5,        32'd2,      32'd0,      1'b0};
    vt[7] = '{mk(6'd0, 5'd10, 6'd32), 32'hFFFFFFFF, 32'd1,      32'd0,      1'b0};
    seq6 = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    b1.instr_valid = 0; b1.instr = 0; b1.rs_data = 0; b1.rt_data = 0; b1.res_ready = 1;
    b4.instr_valid = 0; b4.instr = 0; b4.rs_data = 0; b4.rt_data = 0; b4.res_ready = 1;
    b6.instr_valid = 0; b6.instr = 0; b6.rs_data = 0; b6.rt_data = 0; b6.res_ready = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_instr_ready", b1.instr_ready, 1);
    chk("rst_alu_reset", b1.alu_reset, 1);
    chk("rst_res_valid", b1.res_valid, 0);
    chk("rst_res_data", b1.res_data, 0);
    chk("rst_op_count", b1.op_count, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) run1(vt[i]);
    // backpressure: OR result held while consumer stalls
    b1.res_ready = 0;
    b1.instr = mk(6'd0, 5'd11, 6'd37); b1.rs_data = 32'hA; b1.rt_data = 32'h5; b1.instr_valid = 1;
    @(posedge clk); #1;
    b1.instr_valid = 0;
    lat = 0;
    while (!b1.res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    chk("bp_latency", lat, 1);
    for (int i = 0; i < 10; i++) begin
      b1.instr_valid = i[0];
      b1.instr = mk(6'd0, 5'd20, 6'd32);
      @(posedge clk); #1;
      chk("bp_valid", b1.res_valid, 1);
      chk("bp_data", b1.res_data, 32'hF);
      chk("bp_rd", b1.res_rd, 11);
      chk("bp_ready", b1.instr_ready, 0);
    end
    b1.instr_valid = 0;
    b1.res_ready = 1;
    @(posedge clk); #1;
    exp1++;
    chk("bp_release", b1.res_valid, 0);
    chk("bp_op_count", b1.op_count, exp1);
    @(posedge clk); #1;
    chk("bp_single", b1.res_valid, 0);
    chk("bp_idle_ready", b1.instr_ready, 1);
    // CNT_W=2 wrap and SETTLE_CYCLES=3 latency
    for (int i = 0; i < 5; i++) begin
      b6.instr = mk(6'd0, 5'(i + 1), 6'd32); b6.rs_data = i; b6.rt_data = 1; b6.instr_valid = 1;
      @(posedge clk); #1;
      b6.instr_valid = 0;
      lat = 0;
      while (!b6.res_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("s3_latency", lat, 3);
      chk("s3_data", b6.res_data, i + 1);
      @(posedge clk); #1;
      chk("s3_op_count", b6.op_count, {30'd0, seq6[i]});
    end
    // async reset in the middle of a 4-cycle settle
    b4.instr = mk(6'd0, 5'd2, 6'd32); b4.rs_data = 1; b4.rt_data = 1; b4.instr_valid = 1;
    @(posedge clk); #1;
    b4.instr_valid = 0;
    chk("s4_alu_a", b4.alu_a, 1);
    chk("s4_alu_reset_low", b4.alu_reset, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    chk("mid_rst_ready", b4.instr_ready, 1);
    chk("mid_rst_alu_reset", b4.alu_reset, 1);
    chk("mid_rst_alu_a", b4.alu_a, 0);
    chk("mid_rst_signal", b4.alu_signal, 0);
    chk("mid_rst_res_rd", b4.res_rd, 0);
    #2;
    reset = 1'b0;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (b4.res_valid) hits++;
    end
    chk("no_res_after_rst", hits, 0);
    chk("post_rst_ready", b4.instr_ready, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
